// File: rtl/grid_accum_mem.sv
// Four-bank signed accumulate memory over a 2^PINT x 2^PINT grid, with 3-cycle reads and a one-cycle lazy clear.
// Define GRID_ACCUM_SAT_EN to make the accumulate adder saturate; by default it wraps.
module grid_accum_mem #(
    parameter int WIDTH = 24,
    parameter int PINT  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc_valid,
    input  logic [4*PINT-1:0]  acc_x,
    input  logic [4*PINT-1:0]  acc_y,
    input  logic [4*WIDTH-1:0] acc_din,
    input  logic               rd_valid,
    input  logic [4*PINT-1:0]  rd_x,
    input  logic [4*PINT-1:0]  rd_y,
    output logic [4*WIDTH-1:0] rd_dout,
    output logic               rd_dout_valid,
    output logic               err
);
    localparam int AW    = 2*PINT - 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW-1:0]    addr_t;
    typedef logic [WIDTH-1:0] data_t;

    function automatic data_t add_cell(input data_t a, input data_t b);
`ifdef GRID_ACCUM_SAT_EN
        logic [WIDTH:0] wide;
        wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (wide[WIDTH] != wide[WIDTH-1])
            return wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return wide[WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Cell storage is never reset; the per-cell valid bits mask stale contents.
    data_t            mem  [4][DEPTH];
    logic [DEPTH-1:0] cvld [4];

    logic [1:0] acc_bank [4];
    addr_t      acc_addr [4];
    logic [1:0] rd_bank  [4];
    addr_t      rd_addr  [4];
    logic       acc_dup;
    logic       rd_dup;
    addr_t      s1_addr  [4];
    data_t      s1_din   [4];
    addr_t      rq_addr  [4];

    always_comb begin
        acc_dup = 1'b0;
        rd_dup  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_bank[i] = {acc_y[i*PINT], acc_x[i*PINT]};
            acc_addr[i] = {acc_y[i*PINT+1 +: PINT-1], acc_x[i*PINT+1 +: PINT-1]};
            rd_bank[i]  = {rd_y[i*PINT], rd_x[i*PINT]};
            rd_addr[i]  = {rd_y[i*PINT+1 +: PINT-1], rd_x[i*PINT+1 +: PINT-1]};
            s1_addr[i]  = '0;
            s1_din[i]   = '0;
            rq_addr[i]  = '0;
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (acc_bank[i] == acc_bank[j]) acc_dup = 1'b1;
                if (rd_bank[i] == rd_bank[j])   rd_dup  = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            s1_addr[acc_bank[i]] = acc_addr[i];
            s1_din[acc_bank[i]]  = acc_din[i*WIDTH +: WIDTH];
            rq_addr[rd_bank[i]]  = rd_addr[i];
        end
    end

    // Accumulate pipeline, indexed by bank; all four banks advance together.
    logic       s2_vld, s3_vld, wr_vld;
    addr_t      s2_addr [4];
    data_t      s2_din  [4];
    data_t      s2_q    [4];
    logic [3:0] s2_cv;
    addr_t      s3_addr [4];
    data_t      s3_din  [4];
    data_t      s3_old  [4];
    addr_t      wr_addr [4];
    data_t      wr_dat  [4];
    data_t      sum3    [4];
    data_t      s2_old  [4];

    // Read pipeline: r1 holds per-bank RAM data, r2 holds per-lane masked data.
    logic       r1_vld, r2_vld;
    data_t      r1_q    [4];
    logic [3:0] r1_cv;
    logic [1:0] r1_sel  [4];
    data_t      r2_dat  [4];

    // S2 missed the write landing on the same edge as its read; S3 is newer still, so it wins.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sum3[k] = add_cell(s3_old[k], s3_din[k]);
            if (s3_vld && s3_addr[k] == s2_addr[k])
                s2_old[k] = sum3[k];
            else if (wr_vld && wr_addr[k] == s2_addr[k])
                s2_old[k] = wr_dat[k];
            else if (s2_cv[k])
                s2_old[k] = s2_q[k];
            else
                s2_old[k] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld        <= 1'b0;
            s3_vld        <= 1'b0;
            wr_vld        <= 1'b0;
            r1_vld        <= 1'b0;
            r2_vld        <= 1'b0;
            rd_dout_valid <= 1'b0;
            rd_dout       <= '0;
            err           <= 1'b0;
            for (int k = 0; k < 4; k++) cvld[k] <= '0;
        end else begin
            s2_vld        <= acc_valid && !acc_dup && !clr;
            s3_vld        <= s2_vld && !clr;
            wr_vld        <= s3_vld && !clr;
            r1_vld        <= rd_valid && !rd_dup;
            r2_vld        <= r1_vld;
            rd_dout_valid <= r2_vld;
            for (int i = 0; i < 4; i++) rd_dout[i*WIDTH +: WIDTH] <= r2_dat[i];
            if ((acc_valid && !clr && acc_dup) || (rd_valid && rd_dup)) err <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (clr)
                    cvld[k] <= '0;
                else if (s3_vld)
                    cvld[k][s3_addr[k]] <= 1'b1;
            end
        end
    end

    // Bank RAM ports (read-before-write) and datapath registers carry no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            s2_q[k]    <= mem[k][s1_addr[k]];
            s2_cv[k]   <= cvld[k][s1_addr[k]];
            s2_addr[k] <= s1_addr[k];
            s2_din[k]  <= s1_din[k];
            s3_addr[k] <= s2_addr[k];
            s3_din[k]  <= s2_din[k];
            s3_old[k]  <= s2_old[k];
            wr_addr[k] <= s3_addr[k];
            wr_dat[k]  <= sum3[k];
            r1_q[k]    <= mem[k][rq_addr[k]];
            r1_cv[k]   <= cvld[k][rq_addr[k]] && !clr;
            if (s3_vld && !clr && !rst)
                mem[k][s3_addr[k]] <= sum3[k];
        end
        for (int i = 0; i < 4; i++) begin
            r1_sel[i] <= rd_bank[i];
            r2_dat[i] <= r1_cv[r1_sel[i]] ? r1_q[r1_sel[i]] : '0;
        end
    end
endmodule
